// File: rtl/db15_joy_responder.sv
// db15_joy_responder: device end of the SNAC DB15 joystick serial link.
// Optional stability filter on load/clock: DB15_RESP_GLITCH_FILTER_EN.
module db15_joy_responder #(
    parameter int FRAME_BITS  = 24,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        joy_load,
    input  logic        joy_clk,
    input  logic [11:0] p1_btn,
    input  logic [11:0] p2_btn,
    output logic        joy_data,
    output logic        frame_done,
    output logic [5:0]  bit_index,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    if (FRAME_BITS < 24 || FRAME_BITS > 32 ||
        SYNC_STAGES < 2 || FILT_CYCLES < 1) begin : g_bad_param
        $error("db15_joy_responder: illegal parameter");
    end

    logic [SYNC_STAGES-1:0] r_load_sync;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic                   w_load_s;
    logic                   w_clk_s;
    logic                   w_load_l;
    logic                   w_clk_l;
    logic                   r_clk_prev;
    logic                   w_clk_rise;

    state_t                 r_state;
    state_t                 w_state_n;
    logic [FRAME_BITS-1:0]  r_sreg;
    logic [FRAME_BITS-1:0]  w_sreg_n;
    logic [FRAME_BITS-1:0]  w_load_word;
    logic [5:0]             r_idx;
    logic [5:0]             w_idx_n;
    logic                   r_ovr;
    logic                   w_ovr_n;
    logic                   r_fd;
    logic                   w_fd_n;

    // Bring the async strobes into clk_sys; idle-high after reset.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_load_sync <= '1;
            r_clk_sync  <= '1;
        end else begin
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], joy_load};
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], joy_clk};
        end
    end

    assign w_load_s = r_load_sync[SYNC_STAGES-1];
    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];

`ifdef DB15_RESP_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_CYCLES + 1);

    logic          r_load_f;
    logic          r_clk_f;
    logic [CW-1:0] r_load_cnt;
    logic [CW-1:0] r_clk_cnt;

    // Accept a new level only after FILT_CYCLES consecutive samples of it.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_load_f   <= 1'b1;
            r_clk_f    <= 1'b1;
            r_load_cnt <= '0;
            r_clk_cnt  <= '0;
        end else begin
            if (w_load_s == r_load_f) begin
                r_load_cnt <= '0;
            end else if (r_load_cnt == CW'(FILT_CYCLES - 1)) begin
                r_load_f   <= w_load_s;
                r_load_cnt <= '0;
            end else begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end
            if (w_clk_s == r_clk_f) begin
                r_clk_cnt <= '0;
            end else if (r_clk_cnt == CW'(FILT_CYCLES - 1)) begin
                r_clk_f   <= w_clk_s;
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
        end
    end

    assign w_load_l = r_load_f;
    assign w_clk_l  = r_clk_f;
`else
    assign w_load_l = w_load_s;
    assign w_clk_l  = w_clk_s;
`endif

    // Rising-edge detector on the clean shift clock.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_prev <= w_clk_l;
        end
    end

    assign w_clk_rise = w_clk_l & ~r_clk_prev;

    // Buttons inverted onto the line; padding bits read as released.
    always_comb begin
        w_load_word        = '1;
        w_load_word[23:0]  = {~p2_btn, ~p1_btn};
    end

    // State and datapath registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sreg  <= '1;
            r_idx   <= '0;
            r_ovr   <= 1'b0;
            r_fd    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_sreg  <= w_sreg_n;
            r_idx   <= w_idx_n;
            r_ovr   <= w_ovr_n;
            r_fd    <= w_fd_n;
        end
    end

    // Next state: an active load overrides everything, including edges.
    always_comb begin
        w_state_n = r_state;
        w_sreg_n  = r_sreg;
        w_idx_n   = r_idx;
        w_ovr_n   = r_ovr;
        w_fd_n    = 1'b0;
        if (!w_load_l) begin
            w_state_n = LOAD;
            w_sreg_n  = w_load_word;
            w_idx_n   = '0;
            w_ovr_n   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_n = IDLE;
                end
                LOAD: begin
                    w_state_n = SHIFT;
                end
                SHIFT: begin
                    if (w_clk_rise) begin
                        w_sreg_n = {1'b1, r_sreg[FRAME_BITS-1:1]};
                        w_idx_n  = r_idx + 6'd1;
                        if (r_idx == 6'(FRAME_BITS - 1)) begin
                            w_state_n = DONE;
                            w_fd_n    = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (w_clk_rise) begin
                        w_ovr_n = 1'b1;
                    end
                end
                default: begin
                    w_state_n = IDLE;
                end
            endcase
        end
    end

    assign joy_data   = r_sreg[0];
    assign frame_done = r_fd;
    assign bit_index  = r_idx;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_db15_joy_responder.sv
// tb_db15_joy_responder: directed vectors for the DB15 responder.
// Build with DB15_RESP_GLITCH_FILTER_EN to also cover the filter.
module tb_db15_joy_responder;

`ifdef DB15_RESP_GLITCH_FILTER_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        joy_load;
    logic        joy_clk;
    logic [11:0] p1_btn;
    logic [11:0] p2_btn;
    logic        joy_data;
    logic        frame_done;
    logic [5:0]  bit_index;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;
    int n_fd  = 0;
    int fd0;
    logic [23:0] stream;

    db15_joy_responder dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .joy_load   (joy_load),
        .joy_clk    (joy_clk),
        .p1_btn     (p1_btn),
        .p2_btn     (p2_btn),
        .joy_data   (joy_data),
        .frame_done (frame_done),
        .bit_index  (bit_index),
        .overrun    (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (frame_done === 1'b1) n_fd <= n_fd + 1;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_clk();
        joy_clk = 1'b1;
        step(20);
        joy_clk = 1'b0;
        step(20);
    endtask

    task automatic do_load();
        joy_load = 1'b0;
        step(10);
        joy_load = 1'b1;
        step(12);
    endtask

    initial begin
        reset    = 1'b1;
        joy_load = 1'b1;
        joy_clk  = 1'b0;
        p1_btn   = 12'h001;
        p2_btn   = 12'h000;
        step(3);
        check("rst_data", 32'(joy_data), 32'd1);
        check("rst_idx", 32'(bit_index), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        reset = 1'b0;
        step(2);

        joy_load = 1'b0;
        step(LAT - 1);
        check("load_early", 32'(joy_data), 32'd1);
        step(1);
        check("load_bit0", 32'(joy_data), 32'd0);
        check("load_idx", 32'(bit_index), 32'd0);
        step(10 - LAT);
        joy_load = 1'b1;
        step(12);

        p1_btn = 12'h005;
        p2_btn = 12'h800;
        do_load();
        stream = 24'h7FFFFA;
        fd0 = n_fd;
        for (int k = 0; k < 24; k++) begin
            check($sformatf("stream[%0d]", k), 32'(joy_data),
                  32'(stream[k]));
            if (k == 12) check("mid_idx", 32'(bit_index), 32'd12);
            if (k == 20) p1_btn = 12'hFFF;
            pulse_clk();
        end
        check("fd_once", 32'(n_fd - fd0), 32'd1);
        check("done_data", 32'(joy_data), 32'd1);
        check("done_idx", 32'(bit_index), 32'd24);
        check("done_ovr", 32'(overrun), 32'd0);

        pulse_clk();
        pulse_clk();
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_idx", 32'(bit_index), 32'd24);
        check("ovr_data", 32'(joy_data), 32'd1);
        check("ovr_nofd", 32'(n_fd - fd0), 32'd1);
        joy_load = 1'b0;
        step(LAT + 2);
        check("ovr_clr", 32'(overrun), 32'd0);
        joy_load = 1'b1;
        step(12);

        p1_btn = 12'h001;
        p2_btn = 12'h000;
        do_load();
        for (int k = 0; k < 7; k++) pulse_clk();
        check("pri_idx7", 32'(bit_index), 32'd7);
        check("pri_bit7", 32'(joy_data), 32'd1);
        joy_load = 1'b0;
        joy_clk  = 1'b1;
        step(LAT + 3);
        check("pri_idx", 32'(bit_index), 32'd0);
        check("pri_data", 32'(joy_data), 32'd0);
        joy_clk = 1'b0;
        step(10);
        joy_load = 1'b1;
        joy_clk  = 1'b1;
        step(LAT + 5);
        check("rise_idx", 32'(bit_index), 32'd0);
        check("rise_data", 32'(joy_data), 32'd0);
        joy_clk = 1'b0;
        step(20);
        pulse_clk();
        check("rise_shift", 32'(bit_index), 32'd1);
        check("rise_bit1", 32'(joy_data), 32'd1);

        do_load();
        for (int k = 0; k < 10; k++) pulse_clk();
        check("rmf_idx10", 32'(bit_index), 32'd10);
        reset = 1'b1;
        #1;
        check("rmf_data", 32'(joy_data), 32'd1);
        check("rmf_idx", 32'(bit_index), 32'd0);
        step(2);
        reset = 1'b0;
        step(2);
        for (int k = 0; k < 3; k++) pulse_clk();
        check("rmf_nold_d", 32'(joy_data), 32'd1);
        check("rmf_nold_i", 32'(bit_index), 32'd0);

`ifdef DB15_RESP_GLITCH_FILTER_EN
        do_load();
        joy_clk = 1'b1;
        step(2);
        joy_clk = 1'b0;
        step(20);
        check("glitch2", 32'(bit_index), 32'd0);
        joy_clk = 1'b1;
        step(6);
        joy_clk = 1'b0;
        step(20);
        check("pulse6", 32'(bit_index), 32'd1);
        joy_load = 1'b0;
        step(2);
        joy_load = 1'b1;
        step(20);
        check("ld_glitch", 32'(bit_index), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
